// File: rtl/calc_stack_core.sv
// calc_stack_core: RPN calculator engine -- decimal entry register, DEPTH-deep
// operand stack, 1-cycle add/logic ALU and WIDTH-cycle iterative mul/div.
module calc_stack_core #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       digit_valid,
   input  logic [3:0]                 digit,
   input  logic                       neg_toggle,
   input  logic                       enter,
   input  logic                       op_valid,
   input  logic [2:0]                 opcode,
   input  logic                       clear,
   output logic [WIDTH-1:0]           display,
   output logic                       sign,
   output logic                       o_flag,
   output logic                       err,
   output logic                       busy,
   output logic                       result_valid,
   output logic [$clog2(DEPTH+1)-1:0] depth
);
   localparam int DW = $clog2(DEPTH+1);
   localparam int CW = $clog2(WIDTH+1);
   localparam int XW = WIDTH + 5;
   localparam int M  = WIDTH - 1;
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                          OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_SWAP = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_EXEC, S_ITER} state_t;
   state_t state, state_nx;

   logic [DEPTH-1:0][WIDTH-1:0] stk;
   logic [WIDTH-1:0]   acc, top, sec, acc_base, acc_neg;
   logic [2:0]         op_q;
   logic               idle_ok, go_enter, go_op, go_neg, go_dig, push, full, two;
   logic [XW-1:0]      acc_x, dig_x, dsum;
   logic               dig_ok, neg_ovf;
   logic [WIDTH-1:0]   sum_ab, dif_ab, ma, mb;
   logic               add_ovf, sub_ovf;
   // iterative mul/div state
   logic               mneg;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] p, mc, p_nx;
   logic [WIDTH-1:0]   q, dv, qd_nx;
   logic [WIDTH:0]     r, r_sh, r_nx, dres;
   logic [2*WIDTH:0]   mres;
   logic               ge, last, mul_ok, div_ok;
   // stack commit controls
   logic               wr_sec, wr_top, res_ovf;
   logic [WIDTH-1:0]   sec_val, top_val;

   always_comb begin
      top = '0;
      sec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (DW'(i+1) == depth) top = stk[i];
         if (DW'(i+2) == depth) sec = stk[i];
      end
   end

   assign idle_ok  = (state == S_IDLE) || (state == S_ENTRY);
   assign go_enter = !clear && enter && idle_ok;
   assign go_op    = !clear && !enter && op_valid && idle_ok;
   assign go_neg   = !clear && !enter && !op_valid && neg_toggle && idle_ok;
   assign go_dig   = !clear && !enter && !op_valid && !neg_toggle && digit_valid &&
                     idle_ok && (digit <= 4'd9);
   assign push     = (go_enter || go_op) && (state == S_ENTRY);
   assign full     = depth == DW'(DEPTH);
   assign two      = depth >= DW'(2);

   // acc*10 +/- digit in a widened field; representable iff the top bits agree
   assign acc_base = (state == S_ENTRY) ? acc : '0;
   assign acc_x    = {{5{acc_base[M]}}, acc_base};
   assign dig_x    = {{(WIDTH+1){1'b0}}, digit};
   assign dsum     = acc_base[M] ? (acc_x << 3) + (acc_x << 1) - dig_x
                                 : (acc_x << 3) + (acc_x << 1) + dig_x;
   assign dig_ok   = (&dsum[XW-1:M]) || !(|dsum[XW-1:M]);
   assign acc_neg  = -acc_base;
   assign neg_ovf  = acc_base == MINV;

   assign sum_ab  = sec + top;
   assign dif_ab  = sec - top;
   assign add_ovf = (sec[M] == top[M]) && (sum_ab[M] != sec[M]);
   assign sub_ovf = (sec[M] != top[M]) && (dif_ab[M] != sec[M]);
   assign ma      = sec[M] ? -sec : sec;
   assign mb      = top[M] ? -top : top;

   assign p_nx   = q[0] ? p + mc : p;
   assign r_sh   = {r[WIDTH-1:0], q[M]};
   assign ge     = r_sh >= {1'b0, dv};
   assign r_nx   = ge ? r_sh - {1'b0, dv} : r_sh;
   assign qd_nx  = {q[WIDTH-2:0], ge};
   assign mres   = mneg ? -{1'b0, p_nx} : {1'b0, p_nx};
   assign dres   = mneg ? -{1'b0, qd_nx} : {1'b0, qd_nx};
   assign mul_ok = (&mres[2*WIDTH:M]) || !(|mres[2*WIDTH:M]);
   assign div_ok = (&dres[WIDTH:M]) || !(|dres[WIDTH:M]);
   assign last   = cnt == CW'(WIDTH-1);

   always_comb begin
      wr_sec  = 1'b0;
      wr_top  = 1'b0;
      sec_val = top;
      top_val = sec;
      res_ovf = 1'b0;
      if (!clear && state == S_EXEC && two) begin
         case (op_q)
            OP_ADD:  begin wr_sec = 1'b1; sec_val = sum_ab; res_ovf = add_ovf; end
            OP_SUB:  begin wr_sec = 1'b1; sec_val = dif_ab; res_ovf = sub_ovf; end
            OP_AND:  begin wr_sec = 1'b1; sec_val = sec & top; end
            OP_OR:   begin wr_sec = 1'b1; sec_val = sec | top; end
            OP_XOR:  begin wr_sec = 1'b1; sec_val = sec ^ top; end
            OP_SWAP: begin wr_sec = 1'b1; wr_top = 1'b1; end
            default: ;
         endcase
      end else if (!clear && state == S_ITER && last) begin
         wr_sec = 1'b1;
         if (op_q == OP_MUL) begin
            sec_val = mres[WIDTH-1:0];
            res_ovf = !mul_ok;
         end else begin
            sec_val = dres[WIDTH-1:0];
            res_ovf = !div_ok;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst || clear) state <= S_IDLE;
      else                state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_ENTRY: begin
            if (go_enter)              state_nx = S_IDLE;
            else if (go_op)            state_nx = S_EXEC;
            else if (go_neg || go_dig) state_nx = S_ENTRY;
         end
         S_EXEC: begin
            if (!two)                                     state_nx = S_IDLE;
            else if (op_q == OP_MUL)                      state_nx = S_ITER;
            else if (op_q == OP_DIV && top != '0)         state_nx = S_ITER;
            else                                          state_nx = S_IDLE;
         end
         S_ITER:  if (last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state == S_EXEC) || (state == S_ITER);
      result_valid = wr_sec && nrst;
   end

   always_ff @(posedge clk) begin
      if (!nrst || clear) begin
         stk   <= '0;
         depth <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && DW'(i) == depth) stk[i] <= acc;
            if (wr_sec && DW'(i+2) == depth)      stk[i] <= sec_val;
            if (wr_top && DW'(i+1) == depth)      stk[i] <= top_val;
         end
         if (push && !full)         depth <= depth + DW'(1);
         else if (wr_sec && !wr_top) depth <= depth - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst || clear) begin
         acc    <= '0;
         op_q   <= OP_ADD;
         o_flag <= 1'b0;
         err    <= 1'b0;
      end else begin
         if (go_enter || go_op)   acc <= '0;
         else if (go_neg)         acc <= acc_neg;
         else if (go_dig && dig_ok) acc <= dsum[WIDTH-1:0];
         if (go_op) op_q <= opcode;
         if (go_neg)      o_flag <= neg_ovf;
         else if (go_dig) o_flag <= !dig_ok;
         else if (wr_sec) o_flag <= res_ovf;
         if ((push && full) ||
             (state == S_EXEC && (!two || (op_q == OP_DIV && top == '0))))
            err <= 1'b1;
      end
   end

   // magnitudes loaded in EXEC; q holds multiplier (MUL) or dividend/quotient (DIV)
   always_ff @(posedge clk) begin
      if (state == S_EXEC) begin
         mneg <= sec[M] ^ top[M];
         cnt  <= '0;
         p    <= '0;
         mc   <= {{WIDTH{1'b0}}, ma};
         r    <= '0;
         q    <= (op_q == OP_MUL) ? mb : ma;
         dv   <= mb;
      end else if (state == S_ITER) begin
         cnt <= cnt + CW'(1);
         p   <= p_nx;
         mc  <= mc << 1;
         r   <= r_nx;
         q   <= (op_q == OP_MUL) ? q >> 1 : qd_nx;
      end
   end

   assign display = (state == S_ENTRY) ? acc : ((depth != '0) ? top : '0);
   assign sign    = display[M];
endmodule
